// File: rtl/voice_alloc_pkg.sv
// Shared types, widths and the PS/2 set-2 scancode-to-note map for the voice allocator.
// Notes 1..25 span C3..C5 across the Z row and Q row; note 0 means unmapped.
package voice_alloc_pkg;

    typedef enum logic [1:0] {OFF, ATTACK, SUSTAIN, RELEASE} voice_state_t;
    typedef enum logic [1:0] {IDLE, LOOKUP, SEARCH, COMMIT} fsm_t;

    localparam int NOTE_W = 6;
    localparam int SEQ_W  = 16;

    function automatic logic [NOTE_W-1:0] scan_to_note(input logic [7:0] scan);
        case (scan)
            8'h1A: return 6'd1;   // Z  C3
            8'h1B: return 6'd2;   // S  C#3
            8'h22: return 6'd3;   // X  D3
            8'h23: return 6'd4;   // D  D#3
            8'h21: return 6'd5;   // C  E3
            8'h2A: return 6'd6;   // V  F3
            8'h34: return 6'd7;   // G  F#3
            8'h32: return 6'd8;   // B  G3
            8'h33: return 6'd9;   // H  G#3
            8'h31: return 6'd10;  // N  A3
            8'h3B: return 6'd11;  // J  A#3
            8'h3A: return 6'd12;  // M  B3
            8'h15: return 6'd13;  // Q  C4
            8'h1E: return 6'd14;  // 2  C#4
            8'h1D: return 6'd15;  // W  D4
            8'h26: return 6'd16;  // 3  D#4
            8'h24: return 6'd17;  // E  E4
            8'h2D: return 6'd18;  // R  F4
            8'h2E: return 6'd19;  // 5  F#4
            8'h2C: return 6'd20;  // T  G4
            8'h36: return 6'd21;  // 6  G#4
            8'h35: return 6'd22;  // Y  A4
            8'h3D: return 6'd23;  // 7  A#4
            8'h3C: return 6'd24;  // U  B4
            8'h43: return 6'd25;  // I  C5
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/note_rom.sv
// Registered scancode -> note index -> Q24.8 Hz pitch lookup (equal temperament, A4 = 440 Hz).
// The map and the 64-entry table share one register stage, so both outputs arrive one cycle later.
module note_rom
    import voice_alloc_pkg::*;
(
    input  logic              clk,
    input  logic [7:0]        scancode,
    output logic [NOTE_W-1:0] note,
    output logic [31:0]       freq
);

    logic [NOTE_W-1:0] note_c;

    assign note_c = scan_to_note(scancode);

    always_ff @(posedge clk) begin
        note <= note_c;
        case (note_c)
            6'd1:    freq <= 32'h0000_82D0;
            6'd2:    freq <= 32'h0000_8A97;
            6'd3:    freq <= 32'h0000_92D5;
            6'd4:    freq <= 32'h0000_9B90;
            6'd5:    freq <= 32'h0000_A4D0;
            6'd6:    freq <= 32'h0000_AE9D;
            6'd7:    freq <= 32'h0000_B8FF;
            6'd8:    freq <= 32'h0000_C3FF;
            6'd9:    freq <= 32'h0000_CFA7;
            6'd10:   freq <= 32'h0000_DC00;
            6'd11:   freq <= 32'h0000_E915;
            6'd12:   freq <= 32'h0000_F6F1;
            6'd13:   freq <= 32'h0001_05A0;
            6'd14:   freq <= 32'h0001_152F;
            6'd15:   freq <= 32'h0001_25AA;
            6'd16:   freq <= 32'h0001_3721;
            6'd17:   freq <= 32'h0001_49A1;
            6'd18:   freq <= 32'h0001_5D3A;
            6'd19:   freq <= 32'h0001_71FF;
            6'd20:   freq <= 32'h0001_87FF;
            6'd21:   freq <= 32'h0001_9F4E;
            6'd22:   freq <= 32'h0001_B800;
            6'd23:   freq <= 32'h0001_D22A;
            6'd24:   freq <= 32'h0001_EDE2;
            6'd25:   freq <= 32'h0002_0B40;
            default: freq <= 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: PS/2 make/break events -> per-voice pitch and linear envelope.
// Voice choice: retrigger same held note, else lowest free, else oldest releasing, else oldest held.
module voice_allocator
    import voice_alloc_pkg::*;
#(
    parameter int          VOICES       = 8,
    parameter int          ENV_DIV      = 24000,
    parameter logic [31:0] ATTACK_STEP  = 32'h0100_0000,
    parameter logic [31:0] RELEASE_STEP = 32'h0040_0000,
    parameter logic [31:0] VOL_MAX      = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [10:0]       ps2_key,
    output logic [31:0]       frequencies   [VOICES],
    output logic [31:0]       voice_volumes [VOICES],
    output logic [VOICES-1:0] voice_active,
    output logic              busy,
    output logic [7:0]        drop_count,
    output fsm_t              fsm_state
);

    localparam int IDX_W = $clog2(VOICES);
    localparam int DIV_W = $clog2(ENV_DIV) + 1;

    fsm_t              fsm;
    logic              key_shadow, key_event, pend_valid;
    logic [9:0]        cur_key, pend_key;
    logic [NOTE_W-1:0] note_q;
    logic [31:0]       freq_q;
    logic [IDX_W-1:0]  search_idx, match_idx, off_idx, rel_idx, held_idx, target;
    logic              match_found, off_found, rel_found, held_found;
    logic [SEQ_W-1:0]  rel_age, held_age, seq, cand_age;
    voice_state_t      cand_state;
    logic              cand_held, do_commit, tick;
    logic [DIV_W-1:0]  div_cnt;
    voice_state_t      vstate [VOICES];
    logic [NOTE_W-1:0] vnote  [VOICES];
    logic [SEQ_W-1:0]  vstamp [VOICES];

    note_rom u_note_rom (
        .clk      (clk),
        .scancode (cur_key[7:0]),
        .note     (note_q),
        .freq     (freq_q)
    );

    assign key_event  = ps2_key[10] ^ key_shadow;
    assign busy       = (fsm != IDLE);
    assign fsm_state  = fsm;
    assign cand_state = vstate[search_idx];
    assign cand_held  = (cand_state == ATTACK) || (cand_state == SUSTAIN);
    assign cand_age   = seq - vstamp[search_idx];
    assign tick       = (div_cnt == DIV_W'(ENV_DIV - 1));
    assign do_commit  = (fsm == COMMIT) && (cur_key[9] || match_found);

    always_comb begin
        if (match_found)     target = match_idx;
        else if (off_found)  target = off_idx;
        else if (rel_found)  target = rel_idx;
        else                 target = held_idx;
    end

    always_comb begin
        voice_active = '0;
        for (int i = 0; i < VOICES; i++) voice_active[i] = (vstate[i] != OFF);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm         <= IDLE;
            key_shadow  <= 1'b0;
            cur_key     <= '0;
            pend_key    <= '0;
            pend_valid  <= 1'b0;
            drop_count  <= '0;
            search_idx  <= '0;
            seq         <= '0;
            match_found <= 1'b0;
            off_found   <= 1'b0;
            rel_found   <= 1'b0;
            held_found  <= 1'b0;
            match_idx   <= '0;
            off_idx     <= '0;
            rel_idx     <= '0;
            held_idx    <= '0;
            rel_age     <= '0;
            held_age    <= '0;
        end else begin
            key_shadow <= ps2_key[10];
            // One-deep buffer: an event arriving while one already waits is lost and counted.
            if (fsm == IDLE) begin
                if (pend_valid) begin
                    cur_key    <= pend_key;
                    pend_valid <= key_event;
                    if (key_event) pend_key <= ps2_key[9:0];
                end else if (key_event) begin
                    cur_key <= ps2_key[9:0];
                end
            end else if (key_event) begin
                if (!pend_valid) begin
                    pend_valid <= 1'b1;
                    pend_key   <= ps2_key[9:0];
                end else if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
            case (fsm)
                IDLE: if (pend_valid || key_event) fsm <= LOOKUP;
                LOOKUP: begin
                    search_idx  <= '0;
                    match_found <= 1'b0;
                    off_found   <= 1'b0;
                    rel_found   <= 1'b0;
                    held_found  <= 1'b0;
                    fsm <= (cur_key[8] || scan_to_note(cur_key[7:0]) == '0) ? IDLE : SEARCH;
                end
                SEARCH: begin
                    if (cand_held && vnote[search_idx] == note_q && !match_found) begin
                        match_found <= 1'b1;
                        match_idx   <= search_idx;
                    end
                    if (cand_state == OFF && !off_found) begin
                        off_found <= 1'b1;
                        off_idx   <= search_idx;
                    end
                    // Strict compare keeps the lower index on equal age.
                    if (cand_state == RELEASE && (!rel_found || cand_age > rel_age)) begin
                        rel_found <= 1'b1;
                        rel_idx   <= search_idx;
                        rel_age   <= cand_age;
                    end
                    if (cand_held && (!held_found || cand_age > held_age)) begin
                        held_found <= 1'b1;
                        held_idx   <= search_idx;
                        held_age   <= cand_age;
                    end
                    if (search_idx == IDX_W'(VOICES - 1)) fsm <= COMMIT;
                    else search_idx <= search_idx + 1'b1;
                end
                COMMIT: begin
                    if (cur_key[9]) seq <= seq + 1'b1;
                    fsm <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < VOICES; i++) begin
                vstate[i]        <= OFF;
                vnote[i]         <= '0;
                vstamp[i]        <= '0;
                frequencies[i]   <= '0;
                voice_volumes[i] <= '0;
            end
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                if (do_commit && target == IDX_W'(i)) begin
                    if (!cur_key[9]) begin
                        vstate[i] <= RELEASE;
                    end else begin
                        vstate[i] <= ATTACK;
                        vstamp[i] <= seq;
                        if (!match_found) begin
                            voice_volumes[i] <= '0;
                            frequencies[i]   <= freq_q;
                            vnote[i]         <= note_q;
                        end
                    end
                end else if (tick) begin
                    if (vstate[i] == ATTACK) begin
                        if ({1'b0, voice_volumes[i]} + {1'b0, ATTACK_STEP} >= {1'b0, VOL_MAX}) begin
                            voice_volumes[i] <= VOL_MAX;
                            vstate[i]        <= SUSTAIN;
                        end else begin
                            voice_volumes[i] <= voice_volumes[i] + ATTACK_STEP;
                        end
                    end else if (vstate[i] == RELEASE) begin
                        if (voice_volumes[i] <= RELEASE_STEP) begin
                            voice_volumes[i] <= '0;
                            vstate[i]        <= OFF;
                        end else begin
                            voice_volumes[i] <= voice_volumes[i] - RELEASE_STEP;
                        end
                    end
                end
            end
        end
    end

endmodule
